// File: rtl/rs_wakeup_buffer.sv
// rs_wakeup_buffer: reservation station snooping the serialized writeback bus; issues the
// lowest-index entry whose operands are captured. Optional macro WAKEUP_BYPASS_EN adds same-cycle wakeup-to-issue.
module rs_wakeup_buffer #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned VREG_W  = 5,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned OP_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  logic [OP_W-1:0]              dispatch_op,
  input  logic [VREG_W-1:0]            dispatch_dst_vregid,
  input  logic                         dispatch_rs1_rdy,
  input  logic [VREG_W-1:0]            dispatch_rs1_vregid,
  input  logic [XLEN-1:0]              dispatch_rs1_val,
  input  logic                         dispatch_rs2_rdy,
  input  logic [VREG_W-1:0]            dispatch_rs2_vregid,
  input  logic [XLEN-1:0]              dispatch_rs2_val,
  input  logic                         writeback_en,
  input  logic [VREG_W-1:0]            writeback_vregid,
  input  logic [XLEN-1:0]              writeback_val,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [OP_W-1:0]              issue_op,
  output logic [VREG_W-1:0]            issue_dst_vregid,
  output logic [XLEN-1:0]              issue_val1,
  output logic [XLEN-1:0]              issue_val2,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(ENTRIES + 1);
  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic              rdy;
    logic [VREG_W-1:0] tag;
    logic [XLEN-1:0]   val;
  } opnd_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [VREG_W-1:0] dst;
    opnd_t             rs1;
    opnd_t             rs2;
  } entry_t;

  entry_t           ent_q [ENTRIES];
  entry_t           ent_d [ENTRIES];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  logic [ENTRIES-1:0] wake1_c;
  logic [ENTRIES-1:0] wake2_c;
  logic [ENTRIES-1:0] ok1_c;
  logic [ENTRIES-1:0] ok2_c;
  logic [ENTRIES-1:0] issuable_c;
  logic [XLEN-1:0]    val1_c [ENTRIES];
  logic [XLEN-1:0]    val2_c [ENTRIES];

  logic               sel_found_c;
  logic [IDX_W-1:0]   sel_idx_c;
  logic [IDX_W-1:0]   free_idx_c;
  logic               dispatch_fire_c;
  logic               issue_fire_c;

  // A pending dispatched operand can grab the writeback seen in its own dispatch cycle.
  function automatic opnd_t capture(input logic              rdy,
                                    input logic [VREG_W-1:0] tag,
                                    input logic [XLEN-1:0]   val,
                                    input logic              wb_en,
                                    input logic [VREG_W-1:0] wb_tag,
                                    input logic [XLEN-1:0]   wb_val);
    opnd_t o;
    o.rdy = rdy;
    o.tag = tag;
    o.val = val;
    if (!rdy && wb_en && (tag == wb_tag)) begin
      o.rdy = 1'b1;
      o.val = wb_val;
    end
    return o;
  endfunction

  // Per-entry wakeup match and operand readiness as seen by issue select.
  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      wake1_c[i] = ent_q[i].valid && !ent_q[i].rs1.rdy && writeback_en &&
                   (ent_q[i].rs1.tag == writeback_vregid);
      wake2_c[i] = ent_q[i].valid && !ent_q[i].rs2.rdy && writeback_en &&
                   (ent_q[i].rs2.tag == writeback_vregid);
`ifdef WAKEUP_BYPASS_EN
      ok1_c[i]  = ent_q[i].rs1.rdy || wake1_c[i];
      ok2_c[i]  = ent_q[i].rs2.rdy || wake2_c[i];
      val1_c[i] = ent_q[i].rs1.rdy ? ent_q[i].rs1.val : writeback_val;
      val2_c[i] = ent_q[i].rs2.rdy ? ent_q[i].rs2.val : writeback_val;
`else
      ok1_c[i]  = ent_q[i].rs1.rdy;
      ok2_c[i]  = ent_q[i].rs2.rdy;
      val1_c[i] = ent_q[i].rs1.val;
      val2_c[i] = ent_q[i].rs2.val;
`endif
      issuable_c[i] = ent_q[i].valid && ok1_c[i] && ok2_c[i];
    end
  end

  // Priority pick: lowest ready entry for issue, lowest empty slot for dispatch.
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    free_idx_c  = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (issuable_c[i]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDX_W'(i);
      end
      if (!ent_q[i].valid) begin
        free_idx_c = IDX_W'(i);
      end
    end
  end

  assign dispatch_ready  = (occ_q != OCC_W'(ENTRIES)) && !flush;
  assign dispatch_fire_c = dispatch_valid && dispatch_ready;
  assign issue_fire_c    = issue_valid && issue_ready;
  assign occupancy       = occ_q;

  // Issue port: zeroed payload whenever nothing is offered.
  always_comb begin
    issue_valid      = sel_found_c && !flush;
    issue_op         = '0;
    issue_dst_vregid = '0;
    issue_val1       = '0;
    issue_val2       = '0;
    if (issue_valid) begin
      issue_op         = ent_q[sel_idx_c].op;
      issue_dst_vregid = ent_q[sel_idx_c].dst;
      issue_val1       = val1_c[sel_idx_c];
      issue_val2       = val2_c[sel_idx_c];
    end
  end

  // Entry next state: wakeup, issue release, dispatch fill, flush squash.
  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      ent_d[i] = ent_q[i];
      if (wake1_c[i]) begin
        ent_d[i].rs1.rdy = 1'b1;
        ent_d[i].rs1.val = writeback_val;
      end
      if (wake2_c[i]) begin
        ent_d[i].rs2.rdy = 1'b1;
        ent_d[i].rs2.val = writeback_val;
      end
      if (issue_fire_c && (sel_idx_c == IDX_W'(i))) begin
        ent_d[i].valid = 1'b0;
      end
      if (dispatch_fire_c && (free_idx_c == IDX_W'(i))) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].op    = dispatch_op;
        ent_d[i].dst   = dispatch_dst_vregid;
        ent_d[i].rs1   = capture(dispatch_rs1_rdy, dispatch_rs1_vregid, dispatch_rs1_val,
                                 writeback_en, writeback_vregid, writeback_val);
        ent_d[i].rs2   = capture(dispatch_rs2_rdy, dispatch_rs2_vregid, dispatch_rs2_val,
                                 writeback_en, writeback_vregid, writeback_val);
      end
      if (flush) begin
        ent_d[i].valid = 1'b0;
      end
    end
  end

  // Occupancy tracks accepted dispatches minus accepted issues.
  always_comb begin
    occ_d = occ_q;
    if (dispatch_fire_c && !issue_fire_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!dispatch_fire_c && issue_fire_c) begin
      occ_d = occ_q - OCC_W'(1);
    end
    if (flush) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ent_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ent_q[i] <= ent_d[i];
      end
      occ_q <= occ_d;
    end
  end

endmodule
